// File: rtl/current_switch_array_pkg.sv
// current_switch_array_pkg: shared constants and voltage type for the current switch array
package current_switch_array_pkg;
  localparam int FRAC_BITS = 12;
  localparam int N_ARRAY_DEF = 47;
  localparam int W_IN_DEF = 18;
  localparam int W_OUT_DEF = 16;
  localparam int GAIN_Q16_DEF = 5243;
  localparam int V_OUT_MAX_DEF = 20480;
  localparam int ALPHA_SHIFT_DEF = 2;
  typedef logic signed [W_OUT_DEF-1:0] q12_t;
endpackage

// File: rtl/current_switch_array_core_popcount.sv
// ctrl_popcount: combinational ones counter built as a recursive adder tree
//   bits_i [N-1:0]  input vector
//   cnt_o  [W-1:0]  number of ones in bits_i
module ctrl_popcount #(
  parameter int N = 47,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] cnt_o
);
  generate
    if (N == 1) begin : g_leaf
      assign cnt_o = W'(bits_i);
    end else begin : g_node
      localparam int NL = N / 2;
      localparam int NH = N - NL;
      logic [$clog2(NL+1)-1:0] cnt_lo;
      logic [$clog2(NH+1)-1:0] cnt_hi;
      ctrl_popcount #(.N(NL)) u_lo (.bits_i(bits_i[NL-1:0]), .cnt_o(cnt_lo));
      ctrl_popcount #(.N(NH)) u_hi (.bits_i(bits_i[N-1:NL]), .cnt_o(cnt_hi));
      assign cnt_o = W'(cnt_lo) + W'(cnt_hi);
    end
  endgenerate
endmodule

// File: rtl/current_switch_array_core.sv
// current_switch_array_core: unary switched-current cell bank driving a resistive load
//   clk    emulation clock, rising edge
//   rst_n  synchronous active-low reset
//   v_in   signed Q6.12 input voltage
//   ctrl   cell enables, only the number of ones matters
//   v_out  signed Q4.12 load voltage, registered, 3-register latency
//   CURRENT_SWITCH_ARRAY_FILTER_EN selects the first-order low-pass output stage
module current_switch_array_core
  import current_switch_array_pkg::*;
#(
  parameter int N_ARRAY = N_ARRAY_DEF,
  parameter int W_IN = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int GAIN_Q16 = GAIN_Q16_DEF,
  parameter int V_OUT_MAX = V_OUT_MAX_DEF,
  parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [W_IN-1:0]  v_in,
  input  logic [N_ARRAY-1:0]      ctrl,
  output logic signed [W_OUT-1:0] v_out
);
  localparam int WP = $clog2(N_ARRAY + 1);
  logic [WP-1:0] pop_d, pop_q;
  logic signed [W_IN-1:0] vin_q;
  logic signed [W_OUT-1:0] target_d, target_q, v_out_d, v_out_q;
  logic signed [47:0] prod, rnd;
`ifdef CURRENT_SWITCH_ARRAY_FILTER_EN
  logic signed [W_OUT:0] diff, step;
`endif
  ctrl_popcount #(.N(N_ARRAY)) u_pop (.bits_i(ctrl), .cnt_o(pop_d));
  always_comb begin
    prod = 48'(vin_q) * $signed(48'(pop_q)) * 48'(GAIN_Q16);
    rnd = (prod + 48'sd32768) >>> 16;
    target_d = rnd > 48'(V_OUT_MAX) ? W_OUT'(V_OUT_MAX) :
               rnd < -48'(V_OUT_MAX) ? W_OUT'(-V_OUT_MAX) : W_OUT'(rnd);
`ifdef CURRENT_SWITCH_ARRAY_FILTER_EN
    diff = (W_OUT+1)'(target_q) - (W_OUT+1)'(v_out_q);
    // arithmetic shift of a negative diff never reaches 0, so only small positive gaps need the 1-LSB nudge
    step = (diff > 0 && (diff >>> ALPHA_SHIFT) == 0) ? (W_OUT+1)'(1) : diff >>> ALPHA_SHIFT;
    v_out_d = W_OUT'(v_out_q + step);
`else
    v_out_d = target_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_q <= '0;
      vin_q <= '0;
      target_q <= '0;
      v_out_q <= '0;
    end else begin
      pop_q <= pop_d;
      vin_q <= v_in;
      target_q <= target_d;
      v_out_q <= v_out_d;
    end
  end
  assign v_out = v_out_q;
endmodule

// File: tb/tb_current_switch_array_core.sv
// tb_current_switch_array_core: directed self-checking bench for current_switch_array_core
module tb_current_switch_array_core;
  logic clk = 0;
  logic rst_n;
  logic signed [17:0] v_in;
  logic [46:0] ctrl;
  logic signed [15:0] v_out;
  int checks = 0;
  int failures = 0;
  logic [46:0] all_ones = {47{1'b1}};
`ifdef CURRENT_SWITCH_ARRAY_FILTER_EN
  localparam int FIRST = 5005;
`else
  localparam int FIRST = 20022;
`endif
  current_switch_array_core dut (.clk(clk), .rst_n(rst_n), .v_in(v_in), .ctrl(ctrl), .v_out(v_out));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask
  function automatic int model(input int v, input int p);
    longint x;
    x = (longint'(v) * p * 5243 + 32768) >>> 16;
    return x > 20480 ? 20480 : x < -20480 ? -20480 : int'(x);
  endfunction
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int prev, n;
    rst_n = 0;
    v_in = 18'sd5325;
    ctrl = all_ones;
    settle(1);
    check("rst0", v_out, 0);
    settle(1);
    check("rst1", v_out, 0);
    rst_n = 1;
    settle(1);
    check("lat1", v_out, 0);
    settle(1);
    check("lat2", v_out, 0);
    settle(1);
    check("lat3", v_out, FIRST);
`ifdef CURRENT_SWITCH_ARRAY_FILTER_EN
    prev = FIRST;
    n = 0;
    while (v_out != 16'sd20022 && n < 100) begin
      settle(1);
      check("filt_rise", int'(v_out) > prev, 1);
      prev = v_out;
      n++;
    end
    check("filt_final", v_out, 20022);
    settle(5);
    check("filt_hold", v_out, 20022);
    ctrl = 47'h1;
    settle(4);
    check("filt_fall", int'(v_out) < 20022 && int'(v_out) > 426, 1);
    rst_n = 0;
    settle(1);
    check("filt_rst", v_out, 0);
    settle(1);
    check("filt_rst_hold", v_out, 0);
    rst_n = 1;
    settle(60);
    check("filt_reconv", v_out, 426);
`else
    prev = 20022;
    for (int k = 0; k <= 47; k++) begin
      ctrl = all_ones >> k;
      settle(10);
      check("sweep", v_out, model(5325, 47 - k));
      check("sweep_mono", int'(v_out) <= prev, 1);
      prev = v_out;
      if (k == 0) check("sweep_p47", v_out, 20022);
      if (k == 46) check("sweep_p1", v_out, 426);
      if (k == 47) check("sweep_p0", v_out, 0);
    end
    v_in = 18'sd8192;
    ctrl = all_ones;
    settle(4);
    check("sat_pos", v_out, 20480);
    v_in = -18'sd8192;
    settle(4);
    check("sat_neg", v_out, -20480);
    v_in = -18'sd5325;
    settle(4);
    check("neg_in", v_out, -20022);
    ctrl = '0;
    settle(4);
    check("pop0_neg", v_out, 0);
    v_in = 18'sd5325;
    ctrl = 47'h1;
    settle(4);
    check("pos_bit0", v_out, 426);
    ctrl = 47'h1 << 46;
    settle(4);
    check("pos_bit46", v_out, 426);
    ctrl = 47'h0;
    settle(4);
    v_in = 18'sd5325;
    ctrl = all_ones;
    settle(1);
    ctrl = 47'h1;
    settle(1);
    v_in = -18'sd5325;
    ctrl = all_ones;
    settle(1);
    check("tput_a", v_out, 20022);
    settle(1);
    check("tput_b", v_out, 426);
    settle(1);
    check("tput_c", v_out, -20022);
    rst_n = 0;
    settle(1);
    check("rst_mid", v_out, 0);
    rst_n = 1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/current_switch_array_core.md
# current_switch_array_core

Behavioural, synthesizable fixed-point model of a bank of binary-weighted-free (unary) switched current cells driving a resistive load. Each asserted `ctrl` bit enables one identical cell whose current is proportional to the analog input `v_in`; the summed current develops `v_out` across the load. The block sits in the emulated analog front end, clocked by the global emulation clock, and is the DUT for the current-switch-array regression.

## Interface
- `N_ARRAY`, default 47: number of switch cells (ctrl width).
- `W_IN`, default 18: `v_in` width, signed, 12 fractional bits (Q6.12).
- `W_OUT`, default 16: `v_out` width, signed, 12 fractional bits (Q4.12, ±8 V span).
- `GAIN_Q16`, default 5243: per-cell transfer (I_unit·R_load) in unsigned Q0.16 (≈0.08).
- `V_OUT_MAX`, default 20480: output clamp magnitude in Q12 (5.0 V).
- `ALPHA_SHIFT`, default 2: low-pass coefficient 2^-ALPHA_SHIFT (filter build only).

Ports:
- `clk`  in  1  emulation clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `v_in`  in  W_IN  analog input voltage, signed Q6.12.
- `ctrl`  in  N_ARRAY  cell enables; bit k=1 turns cell k on.
- `v_out`  out  W_OUT  load voltage, signed Q4.12, registered.

## Operation
- Stage 1 (register): `pop` = number of ones in `ctrl` (0..N_ARRAY, 6 bits); `v_in` captured alongside.
- Stage 2 (register): `target` = round(v_in·pop·GAIN_Q16 / 2^16), full-precision product (≥41 bits signed), rounding = add 2^15 then arithmetic shift right 16; result saturated to [−V_OUT_MAX, +V_OUT_MAX].
- Stage 3 (register): `v_out` update (filtered or direct, see Configuration).
- Cell identity: only popcount matters; bit position irrelevant.
- pop=0 → target exactly 0 regardless of `v_in`.
- Negative `v_in` fully supported; clamp symmetric.
- Reset (`rst_n`=0 at an edge): pop, captured v_in, target, v_out all 0 at that edge; holds while asserted; reset mid-transient discards filter state.

## Timing
- Reset value of `v_out`: 0.
- Direct build: a ctrl/v_in change sampled at edge N appears on `v_out` after edge N+2 (3-register latency, no handshake).
- Filter build: `target` valid after edge N+1; `v_out` starts moving at edge N+2, step = (target−v_out) >>> ALPHA_SHIFT; if that shift is 0 but difference ≠0, step = ±1 LSB so `v_out` converges exactly to `target`.
- Inputs may change every cycle; pipeline fully throughput-1.

## Configuration
- Macro `CURRENT_SWITCH_ARRAY_FILTER_EN`.
- Defined: Stage 3 is the first-order low-pass above (models load RC).
- Undefined: Stage 3 copies `target` (v_out = target one cycle later); `ALPHA_SHIFT` unused.

## Structure
- Package `current_switch_array_pkg`: fractional-bit count (12), default widths, `GAIN_Q16`, `V_OUT_MAX`, `ALPHA_SHIFT` constants, and a `q12_t` signed typedef for voltages.
- One sub-module: `ctrl_popcount` (parameterized N-input ones counter, combinational, adder tree), instantiated in Stage 1.
- Top keeps multiply, round, saturate, and filter logic.

## Test plan
- Reset: rst_n=0 two cycles with ctrl all ones, v_in=1.3 → v_out=0 throughout; after release, direct build v_out=20022 (≈4.888 V) three edges later.
- Shift-down sweep: v_in=5325 (1.3 V), ctrl=all 47 ones, shift right by 1 every 10 cycles → settled v_out per step = round(5325·pop·5243/65536): pop 47→20022, pop 1→426, pop 0→0; monotonic non-increasing.
- Saturation: v_in=8192 (2.0 V), all ones → unclamped 30803 clamped to 20480; v_in=−8192 → −20480.
- Negative input: v_in=−5325, all ones → −20022.
- Position independence: ctrl=47'h1 vs single bit at position 46 → identical v_out (426).
- Filter build: 0→all ones step at v_in=1.3 → first update 5005, strictly increasing, reaches exactly 20022 and holds; mid-transient rst_n pulse → v_out 0 at that edge.
